// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, optional zero register,
// optional write-to-read bypass and a registered count of pending registers.
module regfile_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   RAddr1_RF,
  input  logic [AW-1:0]   RAddr2_RF,
  output logic [XLEN-1:0] RD1_RF,
  output logic [XLEN-1:0] RD2_RF,
  output logic            Busy1_RF,
  output logic            Busy2_RF,
  input  logic            WrEn_RF,
  input  logic [AW-1:0]   WAddr_RF,
  input  logic [XLEN-1:0] WD_RF,
  input  logic            Iss_RF,
  input  logic [AW-1:0]   IssAddr_RF,
  output logic [AW:0]     PendCnt_RF,
  output logic            Full_RF
);

  localparam bit            ZERO_EN   = (ZERO_REG != 0);
  localparam bit            BYP_EN    = (BYPASS != 0);
  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam logic [AW:0]   MAX_CNT   = (AW+1)'(NREG - ZERO_REG);

  logic [XLEN-1:0] mem_r [NREG];
  logic [NREG-1:0] pend_r;
  logic [NREG-1:0] pend_nxt_s;
  logic [AW:0]     cnt_r;
  logic [AW:0]     cnt_nxt_s;
  logic            full_r;
  logic            wr_eff_s;
  logic            iss_eff_s;
  logic            set_s;
  logic            clr_s;

  // Qualify write/issue, derive next pending vector and count delta.
  always_comb begin
    wr_eff_s   = 1'b0;
    iss_eff_s  = 1'b0;
    set_s      = 1'b0;
    clr_s      = 1'b0;
    pend_nxt_s = pend_r;
    cnt_nxt_s  = cnt_r;
    if (WrEn_RF && !(ZERO_EN && (WAddr_RF == ZERO_ADDR))) begin
      wr_eff_s = 1'b1;
    end else begin
      wr_eff_s = 1'b0;
    end
    // Full blocks issues, so the count can never exceed MAX_CNT.
    if (Iss_RF && !full_r && !(ZERO_EN && (IssAddr_RF == ZERO_ADDR))) begin
      iss_eff_s = 1'b1;
    end else begin
      iss_eff_s = 1'b0;
    end
    set_s = iss_eff_s && !pend_r[IssAddr_RF];
    clr_s = wr_eff_s && pend_r[WAddr_RF] && !(iss_eff_s && (IssAddr_RF == WAddr_RF));
    if (wr_eff_s) begin
      pend_nxt_s[WAddr_RF] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (iss_eff_s) begin
      pend_nxt_s[IssAddr_RF] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    case ({set_s, clr_s})
      2'b10:   cnt_nxt_s = cnt_r + {{AW{1'b0}}, 1'b1};
      2'b01:   cnt_nxt_s = cnt_r - {{AW{1'b0}}, 1'b1};
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Data array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_r[i] <= {XLEN{1'b0}};
    end else if (wr_eff_s) begin
      mem_r[WAddr_RF] <= WD_RF;
    end
  end

  // Pending bits, pending count and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NREG{1'b0}};
      cnt_r  <= {(AW+1){1'b0}};
      full_r <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
      full_r <= (cnt_nxt_s == MAX_CNT);
    end
  end

  // Read port 1.
  always_comb begin
    RD1_RF   = mem_r[RAddr1_RF];
    Busy1_RF = pend_r[RAddr1_RF];
    if (ZERO_EN && (RAddr1_RF == ZERO_ADDR)) begin
      RD1_RF   = {XLEN{1'b0}};
      Busy1_RF = 1'b0;
    end else if (BYP_EN && WrEn_RF && (WAddr_RF == RAddr1_RF)) begin
      RD1_RF   = WD_RF;
      Busy1_RF = 1'b0;
    end else begin
      RD1_RF   = mem_r[RAddr1_RF];
      Busy1_RF = pend_r[RAddr1_RF];
    end
  end

  // Read port 2.
  always_comb begin
    RD2_RF   = mem_r[RAddr2_RF];
    Busy2_RF = pend_r[RAddr2_RF];
    if (ZERO_EN && (RAddr2_RF == ZERO_ADDR)) begin
      RD2_RF   = {XLEN{1'b0}};
      Busy2_RF = 1'b0;
    end else if (BYP_EN && WrEn_RF && (WAddr_RF == RAddr2_RF)) begin
      RD2_RF   = WD_RF;
      Busy2_RF = 1'b0;
    end else begin
      RD2_RF   = mem_r[RAddr2_RF];
      Busy2_RF = pend_r[RAddr2_RF];
    end
  end

  assign PendCnt_RF = cnt_r;
  assign Full_RF    = full_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array/popcount reference model compared every
// negative edge, plus directed literal expectations for the key scenarios.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, ia;
  logic [31:0] rd1, rd2, wd;
  logic        busy1, busy2, we, iss, full;
  logic [5:0]  cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  logic        m_pend [32];

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .RAddr1_RF(ra1), .RAddr2_RF(ra2),
    .RD1_RF(rd1), .RD2_RF(rd2),
    .Busy1_RF(busy1), .Busy2_RF(busy2),
    .WrEn_RF(we), .WAddr_RF(wa), .WD_RF(wd),
    .Iss_RF(iss), .IssAddr_RF(ia),
    .PendCnt_RF(cnt), .Full_RF(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return 32'd0;
    return {31'd0, m_pend[a]};
  endfunction

  // Reference model: reset clears everything, writes clear pending, issues set it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_pend[i] = 1'b0;
      end
    end else begin
      automatic bit was_full = (popcount() == 31);
      if (we && wa != 5'd0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (iss && ia != 5'd0 && !was_full) m_pend[ia] = 1'b1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("busy1", {31'd0, busy1}, exp_busy(ra1));
    chk("busy2", {31'd0, busy2}, exp_busy(ra2));
    chk("pendcnt", {26'd0, cnt}, popcount());
    chk("full", {31'd0, full}, {31'd0, popcount() == 31});
  end

  // Apply one cycle of inputs just after a rising edge, return just after the falling edge.
  task automatic step(input logic w, input logic [4:0] wad, input logic [31:0] wdat,
                      input logic is, input logic [4:0] iad,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk); #1;
    we = w; wa = wad; wd = wdat; iss = is; ia = iad; ra1 = r1; ra2 = r2;
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; wa = 5'd0; wd = 32'd0; iss = 1'b0; ia = 5'd0; ra1 = 5'd0; ra2 = 5'd0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("lit_reset_cnt", {26'd0, cnt}, 32'd0);
    chk("lit_reset_full", {31'd0, full}, 32'd0);

    // Basic write then dual-port read
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    chk("lit_x5_rd1", rd1, 32'hDEADBEEF);
    chk("lit_x5_rd2", rd2, 32'hDEADBEEF);
    chk("lit_x5_busy1", {31'd0, busy1}, 32'd0);

    // Zero register ignores writes and issues
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_x0_rd1", rd1, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_x0_cnt", {26'd0, cnt}, 32'd0);

    // Issue then bypassed write clears busy
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("lit_x7_busy1", {31'd0, busy1}, 32'd1);
    chk("lit_x7_cnt", {26'd0, cnt}, 32'd1);
    step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("lit_x7_byp_rd1", rd1, 32'hA5A5A5A5);
    chk("lit_x7_byp_busy1", {31'd0, busy1}, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("lit_x7_cnt_after", {26'd0, cnt}, 32'd0);

    // Same-address issue+write: issue wins
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    chk("lit_x3_rd1", rd1, 32'h1);
    chk("lit_x3_busy1", {31'd0, busy1}, 32'd1);
    chk("lit_x3_cnt", {26'd0, cnt}, 32'd1);
    step(1'b1, 5'd3, 32'h2, 1'b1, 5'd4, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd3);
    chk("lit_x4x3_cnt", {26'd0, cnt}, 32'd1);
    chk("lit_x4_busy1", {31'd0, busy1}, 32'd1);
    chk("lit_x3_busy2", {31'd0, busy2}, 32'd0);
    chk("lit_x3_rd2", rd2, 32'h2);

    // Fill the scoreboard
    for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_full_cnt", {26'd0, cnt}, 32'd31);
    chk("lit_full_flag", {31'd0, full}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_full_hold", {26'd0, cnt}, 32'd31);

    // x9 gets 0xFF and is pending again
    step(1'b1, 5'd9, 32'hFF, 1'b0, 5'd0, 5'd9, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    chk("lit_x9_cnt30", {26'd0, cnt}, 32'd30);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
    chk("lit_x9_rd1", rd1, 32'hFF);
    chk("lit_x9_busy1", {31'd0, busy1}, 32'd1);
    chk("lit_x9_cnt31", {26'd0, cnt}, 32'd31);

    // Asynchronous reset pulse between edges
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_rd1", rd1, 32'd0);
    chk("lit_rst_busy1", {31'd0, busy1}, 32'd0);
    chk("lit_rst_cnt", {26'd0, cnt}, 32'd0);
    chk("lit_rst_full", {31'd0, full}, 32'd0);

    // Bypass visible during reset, but no write lands
    step(1'b1, 5'd6, 32'hCAFE0001, 1'b1, 5'd6, 5'd6, 5'd9);
    chk("lit_rst_byp_rd1", rd1, 32'hCAFE0001);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd9);
    chk("lit_rst_nowrite", rd1, 32'd0);
    rst_n = 1'b1;

    // Normal operation after release
    step(1'b1, 5'd2, 32'h55, 1'b1, 5'd8, 5'd2, 5'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd8);
    chk("lit_post_rd1", rd1, 32'h55);
    chk("lit_post_busy2", {31'd0, busy2}, 32'd1);
    chk("lit_post_cnt", {26'd0, cnt}, 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL expose parameter NREG, default 32, number of architectural registers (power of two, >=2).
REQ-003 The block SHALL expose parameter ZERO_REG, default 1, meaning register 0 reads as zero and ignores writes and issues.
REQ-004 The block SHALL expose parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-005 The block SHALL derive localparam AW = clog2(NREG), the address width.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 RAddr1_RF, RAddr2_RF  input  AW  read addresses for ports 1 and 2.
REQ-009 RD1_RF, RD2_RF  output  XLEN  read data for ports 1 and 2.
REQ-010 Busy1_RF, Busy2_RF  output  1  pending status of the register read on ports 1 and 2.
REQ-011 WrEn_RF  input  1  write enable; WAddr_RF input AW write address; WD_RF input XLEN write data.
REQ-012 Iss_RF  input  1  issue strobe, marking IssAddr_RF (input AW) as pending.
REQ-013 PendCnt_RF  output  AW+1  number of registers currently marked pending.
REQ-014 Full_RF  output  1  asserted when PendCnt_RF equals NREG-ZERO_REG.

Function
REQ-015 The block SHALL hold NREG data registers of XLEN bits and NREG pending bits.
REQ-016 A write SHALL update register WAddr_RF with WD_RF on the rising clk edge when WrEn_RF=1.
REQ-017 A write SHALL clear the pending bit of WAddr_RF on the same edge.
REQ-018 An issue SHALL set the pending bit of IssAddr_RF on the rising clk edge when Iss_RF=1.
REQ-019 If Iss_RF and WrEn_RF target the same address in one cycle, the block SHALL write the data and leave the pending bit SET (the issue wins).
REQ-020 Reads SHALL be combinational: RDn_RF is the stored value of RAddrn_RF and Busyn_RF is its pending bit.
REQ-021 With BYPASS=1, if WrEn_RF=1 and WAddr_RF equals RAddrn_RF, the block SHALL drive RDn_RF=WD_RF and Busyn_RF=0 in the same cycle.
REQ-022 With BYPASS=0, a read SHALL return the old value until the cycle after the write.
REQ-023 With ZERO_REG=1, address 0 SHALL always read as 0 with Busy 0, including under bypass; writes and issues to address 0 SHALL be ignored and SHALL NOT change PendCnt_RF.
REQ-024 PendCnt_RF SHALL be a registered counter updated on each edge by +1 for each effective 0->1 pending transition and -1 for each effective 1->0 transition; the net change per cycle SHALL be in {-1, 0, +1}.
REQ-025 An issue to an already-pending register SHALL NOT increment PendCnt_RF; a write to a non-pending register SHALL NOT decrement it.
REQ-026 When issue and write target different addresses in one cycle, both SHALL take effect and PendCnt_RF SHALL change by their net effect.
REQ-027 PendCnt_RF SHALL never wrap; it SHALL stay within 0..NREG-ZERO_REG by construction.
REQ-028 An issue while Full_RF=1 SHALL have no effect on state.

Reset
REQ-029 When rst_n=0, the block SHALL immediately clear all data registers to 0, clear all pending bits, and clear PendCnt_RF to 0, independent of clk.
REQ-030 During reset, RD1_RF, RD2_RF, Busy1_RF, Busy2_RF and Full_RF SHALL read 0, except RDn_RF under bypass with WrEn_RF=1, which SHALL show WD_RF.
REQ-031 Writes and issues SHALL be ignored while rst_n=0; the first edge after deassertion SHALL operate normally.
REQ-032 Reset asserted mid-sequence SHALL discard all pending state without any partial update.

Verification
REQ-033 Write 0xDEADBEEF to x5, then read x5 on both ports next cycle -> RD1_RF=RD2_RF=0xDEADBEEF, Busy=0.
REQ-034 Write 0x12345678 to x0, then read x0 -> RD=0, PendCnt_RF=0; issue x0 -> PendCnt_RF stays 0.
REQ-035 Issue x7 -> next cycle Busy1_RF=1, PendCnt_RF=1; then WrEn x7=0xA5A5A5A5 while reading x7 -> same cycle RD1_RF=0xA5A5A5A5 and Busy1_RF=0 (BYPASS=1), next cycle PendCnt_RF=0.
REQ-036 Issue x3 and write x3=0x1 in one cycle -> next cycle RD=0x1, Busy=1, PendCnt_RF=1; issue x4 and write x3 together -> PendCnt_RF stays 1.
REQ-037 Issue x1..x31 over consecutive cycles -> PendCnt_RF=31, Full_RF=1; a further issue causes no change.
REQ-038 Pulse rst_n low between clock edges with x9 pending and holding 0xFF -> immediately RD=0, Busy=0, PendCnt_RF=0.
